// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: global control-state codes, the NOP
// encoding, the fetch FSM encoding and the sequential PC increment.
package instr_fetch_unit_pkg;

  localparam logic [3:0] ST_FETCH  = 4'b0000;
  localparam logic [3:0] ST_DECODE = 4'b0001;
  localparam logic [3:0] ST_EXEC   = 4'b0010;
  localparam logic [3:0] ST_MEM    = 4'b0011;
  localparam logic [3:0] ST_PCUPD  = 4'b0100;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_INC    = 4;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Combinational next-PC: sequential +4, or PC plus/minus the decoder's
// sign-magnitude immediate when the branch is taken. Flags a misaligned result.
module pc_next_calc
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              taken,
  input  logic [11:0]       immediate,
  input  logic              negative,
  output logic [ADDR_W-1:0] next_pc,
  output logic              misalign
);

  logic [ADDR_W-1:0] offset;

  // Arithmetic wraps modulo 2^ADDR_W in both directions.
  always_comb begin
    offset = ADDR_W'(immediate);
    if (!taken)        next_pc = pc + ADDR_W'(PC_INC);
    else if (negative) next_pc = pc - offset;
    else               next_pc = pc + offset;
  end

  assign misalign = |next_pc[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches over a req/ready handshake into the IR.
// Optional build macro MISALIGN_CHECK_EN adds a sticky misalign_err output.
module instr_fetch_unit
  import instr_fetch_unit_pkg::fetch_state_t, instr_fetch_unit_pkg::FS_IDLE,
         instr_fetch_unit_pkg::FS_REQ, instr_fetch_unit_pkg::FS_DONE,
         instr_fetch_unit_pkg::NOP_INSTR;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [3:0]        ST_FETCH = 4'b0000,
  parameter logic [3:0]        ST_PCUPD = 4'b0100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        state,
  input  logic              branch_taken,
  input  logic [11:0]       immediate,
  input  logic              negative,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_done,
  output logic              busy,
`ifdef MISALIGN_CHECK_EN
  output logic              misalign_err,
`endif
  output logic [1:0]        dbg_fsm
);

  // Handshake: imem_req is held with a stable imem_addr until the cycle in
  // which imem_ready is sampled high; that edge completes the transfer.
  fetch_state_t fsm_q, fsm_d;
  logic fetch_q, pcupd_q, pend_q, br_q, neg_q;
  logic [11:0] imm_q;
  logic fetch_rise, pcupd_rise, launch_ok, upd_now;
  logic calc_taken, calc_neg;
  logic [11:0] calc_imm;
  logic [ADDR_W-1:0] next_pc;
  logic misalign;

  assign fetch_rise = (state == ST_FETCH) && !fetch_q;
  assign pcupd_rise = (state == ST_PCUPD) && !pcupd_q;
  // A PC update may only land while idle so imem_addr never moves mid-request.
  assign upd_now    = (fsm_q == FS_IDLE) && (pcupd_rise || pend_q);

  assign calc_taken = pend_q ? br_q  : branch_taken;
  assign calc_imm   = pend_q ? imm_q : immediate;
  assign calc_neg   = pend_q ? neg_q : negative;

`ifdef MISALIGN_CHECK_EN
  assign launch_ok = fetch_rise && !misalign_err;
`else
  assign launch_ok = fetch_rise;
  logic misalign_unused;
  assign misalign_unused = misalign;
`endif

  pc_next_calc #(.ADDR_W(ADDR_W)) u_pc_next_calc (
    .pc        (pc),
    .taken     (calc_taken),
    .immediate (calc_imm),
    .negative  (calc_neg),
    .next_pc   (next_pc),
    .misalign  (misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= FS_IDLE;
      fetch_q <= 1'b0;
      pcupd_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      fetch_q <= (state == ST_FETCH);
      pcupd_q <= (state == ST_PCUPD);
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      FS_IDLE: if (launch_ok)  fsm_d = FS_REQ;
      FS_REQ:  if (imem_ready) fsm_d = FS_DONE;
      FS_DONE: fsm_d = FS_IDLE;
      default: fsm_d = FS_IDLE;
    endcase
  end

  assign imem_req   = (fsm_q == FS_REQ);
  assign fetch_done = (fsm_q == FS_DONE);
  assign busy       = (fsm_q != FS_IDLE);
  assign imem_addr  = pc;
  assign dbg_fsm    = fsm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instruction <= NOP_INSTR;
    else if (fsm_q == FS_REQ && imem_ready) instruction <= imem_rdata;
  end

  // Branch operands are captured at the ST_PCUPD edge if the update must wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      br_q   <= 1'b0;
      imm_q  <= '0;
      neg_q  <= 1'b0;
    end else if (pcupd_rise && !(fsm_q == FS_IDLE && !pend_q)) begin
      pend_q <= 1'b1;
      br_q   <= branch_taken;
      imm_q  <= immediate;
      neg_q  <= negative;
    end else if (upd_now) begin
      pend_q <= 1'b0;
    end
  end

`ifdef MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else if (upd_now) begin
      if (misalign) misalign_err <= 1'b1;
      else          pc <= next_pc;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pc <= RESET_PC;
    else if (upd_now) pc <= next_pc;
  end
`endif

endmodule
